// File: rtl/dmem_access_pkg.sv
// dmem_access_pkg: shared encodings for the MEM-stage data-bus master.
//    memread codes (LD_*), memwrite codes (ST_*), bus size codes (SZ_*),
//    and the access FSM state type.
package dmem_access_pkg;
   localparam logic [2:0] LD_W    = 3'b000;
   localparam logic [2:0] LD_H    = 3'b001;
   localparam logic [2:0] LD_HU   = 3'b101;
   localparam logic [2:0] LD_NONE = 3'b111;
   localparam logic [1:0] ST_NONE = 2'b00;
   localparam logic [1:0] ST_W    = 2'b01;
   localparam logic [1:0] ST_H    = 2'b10;
   localparam logic [1:0] SZ_B    = 2'd0;
   localparam logic [1:0] SZ_H    = 2'd1;
   localparam logic [1:0] SZ_W    = 2'd2;
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_DRAIN} state_e;
endpackage

// File: rtl/dmem_access_store_align.sv
// dmem_access_store_align: decodes the access kind and size, checks alignment,
//    and builds the byte strobes and replicated store data.
//    in : memread_i, memwrite_i, addr_lo_i (addr[1:0]), wdata_i
//    out: is_load_o, is_store_o, misaligned_o, size_o, wstrb_o, wdata_o
module dmem_access_store_align
   import dmem_access_pkg::*;
(
   input  logic [2:0]  memread_i,
   input  logic [1:0]  memwrite_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] wdata_i,
   output logic        is_load_o,
   output logic        is_store_o,
   output logic        misaligned_o,
   output logic [1:0]  size_o,
   output logic [3:0]  wstrb_o,
   output logic [31:0] wdata_o
);
   always_comb begin
      is_load_o    = memread_i != LD_NONE;
      is_store_o   = memwrite_i != ST_NONE;
      size_o       = is_store_o ? (memwrite_i == ST_W ? SZ_W : memwrite_i == ST_H ? SZ_H : SZ_B)
                                : (memread_i == LD_W ? SZ_W : memread_i inside {LD_H, LD_HU} ? SZ_H : SZ_B);
      misaligned_o = size_o == SZ_W ? |addr_lo_i : (size_o == SZ_H) & addr_lo_i[0];
      wstrb_o      = !is_store_o ? 4'b0000 : size_o == SZ_W ? 4'b1111
                   : size_o == SZ_H ? 4'b0011 << addr_lo_i : 4'b0001 << addr_lo_i;
      wdata_o      = size_o == SZ_B ? {4{wdata_i[7:0]}} : size_o == SZ_H ? {2{wdata_i[15:0]}} : wdata_i;
   end
endmodule

// File: rtl/dmem_access.sv
// dmem_access: MEM-stage data-bus master driving an SRAM-like req/addr_ok/data_ok bus.
//    Pipeline side: mem_valid, memread, memwrite, addr, wdata, flush, stall_in in;
//                   stall_out, rdata_out (raw word), exp_adel, exp_ades, badvaddr out.
//    Bus side     : data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata out;
//                   data_addr_ok, data_data_ok, data_rdata in.
//    Optional macro DMEM_ADDR_MAP_EN: fold kseg0/kseg1 onto physical address 0.
module dmem_access
   import dmem_access_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          mem_valid,
   input  logic [2:0]    memread,
   input  logic [1:0]    memwrite,
   input  logic [31:0]   addr,
   input  logic [31:0]   wdata,
   input  logic          flush,
   input  logic          stall_in,
   output logic          stall_out,
   output logic [31:0]   rdata_out,
   output logic          exp_adel,
   output logic          exp_ades,
   output logic [31:0]   badvaddr,
   output logic          data_req,
   output logic          data_wr,
   output logic [1:0]    data_size,
   output logic [AW-1:0] data_addr,
   output logic [3:0]    data_wstrb,
   output logic [DW-1:0] data_wdata,
   input  logic          data_addr_ok,
   input  logic          data_data_ok,
   input  logic [DW-1:0] data_rdata
);
   logic          is_load, is_store, misaligned, go;
   logic [31:0]   vaddr, paddr;
   logic [DW-1:0] rdata_q, rdata_d;
   state_e        state_q, state_d;

   dmem_access_store_align u_align (
      .memread_i   (memread),
      .memwrite_i  (memwrite),
      .addr_lo_i   (addr[1:0]),
      .wdata_i     (wdata),
      .is_load_o   (is_load),
      .is_store_o  (is_store),
      .misaligned_o(misaligned),
      .size_o      (data_size),
      .wstrb_o     (data_wstrb),
      .wdata_o     (data_wdata)
   );

   assign go        = mem_valid & (is_load | is_store) & ~misaligned;
   assign exp_adel  = mem_valid & is_load & misaligned;
   assign exp_ades  = mem_valid & is_store & misaligned;
   assign badvaddr  = addr;
   assign data_req  = (state_q == S_IDLE) & go;
   assign data_wr   = is_store;
   // DRAIN keeps the stage held so a new access cannot issue before the stale data_ok is absorbed
   assign stall_out = mem_valid & ((go & state_q != S_DONE) | state_q == S_DRAIN);
   assign rdata_out = rdata_q;
   assign vaddr     = data_size == SZ_W ? {addr[31:2], 2'b00} : addr;
`ifdef DMEM_ADDR_MAP_EN
   assign paddr     = vaddr[31:30] == 2'b10 ? {3'b000, vaddr[28:0]} : vaddr;
`else
   assign paddr     = vaddr;
`endif
   assign data_addr = paddr[AW-1:0];

   always_comb begin
      state_d = state_q;
      rdata_d = rdata_q;
      case (state_q)
         S_IDLE:
            if (data_req & data_addr_ok) begin
               // a flushed access finishing in its own request cycle needs no draining
               state_d = data_data_ok ? (flush ? S_IDLE : S_DONE) : (flush ? S_DRAIN : S_WAIT);
               rdata_d = data_data_ok & ~flush ? data_rdata : rdata_q;
            end
         S_WAIT: begin
            state_d = data_data_ok ? (flush ? S_IDLE : S_DONE) : (flush ? S_DRAIN : S_WAIT);
            rdata_d = data_data_ok & ~flush ? data_rdata : rdata_q;
         end
         S_DONE:  state_d = flush | ~stall_in ? S_IDLE : S_DONE;
         S_DRAIN: state_d = data_data_ok ? S_IDLE : S_DRAIN;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
      end
   end
endmodule

// File: tb/tb_dmem_access.sv
// tb_dmem_access: directed self-checking bench for dmem_access.
module tb_dmem_access;
   logic        clk = 1'b0, resetn = 1'b0;
   logic        mem_valid = 1'b0, flush = 1'b0, stall_in = 1'b0;
   logic [2:0]  memread = 3'b111;
   logic [1:0]  memwrite = 2'b00;
   logic [31:0] addr = '0, wdata = '0;
   logic        data_addr_ok = 1'b0, data_data_ok = 1'b0;
   logic [31:0] data_rdata = '0;
   logic        stall_out, exp_adel, exp_ades, data_req, data_wr;
   logic [31:0] rdata_out, badvaddr, data_addr, data_wdata;
   logic [1:0]  data_size;
   logic [3:0]  data_wstrb;
   int          checks = 0, failures = 0;

   dmem_access dut (
      .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .memread(memread), .memwrite(memwrite),
      .addr(addr), .wdata(wdata), .flush(flush), .stall_in(stall_in), .stall_out(stall_out),
      .rdata_out(rdata_out), .exp_adel(exp_adel), .exp_ades(exp_ades), .badvaddr(badvaddr),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
      .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok), .data_rdata(data_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2;
      chk("rst_rdata", rdata_out, 0);
      chk("rst_req", data_req, 0);
      chk("rst_stall", stall_out, 0);
      chk("rst_adel", exp_adel, 0);
      chk("rst_ades", exp_ades, 0);
      tick();
      resetn = 1'b1;
      tick();
      // LW with addr_ok in the request cycle, data_ok one cycle later
      mem_valid = 1; memread = 3'b000; addr = 32'h0000_1004; data_addr_ok = 1;
      #2;
      chk("lw_req", data_req, 1);
      chk("lw_stall0", stall_out, 1);
      chk("lw_addr", data_addr, 32'h0000_1004);
      chk("lw_wr", data_wr, 0);
      chk("lw_size", data_size, 2);
      chk("lw_wstrb", data_wstrb, 0);
      tick();
      data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'hDEAD_BEEF;
      #2;
      chk("lw_wait_req", data_req, 0);
      chk("lw_stall1", stall_out, 1);
      tick();
      data_data_ok = 0;
      #2;
      chk("lw_rdata", rdata_out, 32'hDEAD_BEEF);
      chk("lw_done_stall", stall_out, 0);
      tick();
      mem_valid = 0; memread = 3'b111;
      // SB to byte 3
      tick();
      mem_valid = 1; memwrite = 2'b11; addr = 32'h0000_0103; wdata = 32'h0000_0055;
      #2;
      chk("sb_wstrb", data_wstrb, 4'b1000);
      chk("sb_wdata", data_wdata, 32'h5555_5555);
      chk("sb_size", data_size, 0);
      chk("sb_wr", data_wr, 1);
      chk("sb_req", data_req, 1);
      chk("sb_addr", data_addr, 32'h0000_0103);
      tick();
      data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'h0;
      #2;
      chk("sb_stall", stall_out, 1);
      tick();
      data_addr_ok = 0; data_data_ok = 0;
      #2;
      chk("sb_done_stall", stall_out, 0);
      chk("sb_done_req", data_req, 0);
      tick();
      mem_valid = 0; memwrite = 2'b00;
      // alignment faults and aligned SH
      tick();
      mem_valid = 1; memread = 3'b001; addr = 32'h0000_1001;
      #2;
      chk("lh_adel", exp_adel, 1);
      chk("lh_ades", exp_ades, 0);
      chk("lh_badva", badvaddr, 32'h0000_1001);
      chk("lh_req", data_req, 0);
      chk("lh_stall", stall_out, 0);
      memread = 3'b111; memwrite = 2'b01; addr = 32'h0000_1002;
      #2;
      chk("sw_ades", exp_ades, 1);
      chk("sw_adel", exp_adel, 0);
      chk("sw_req", data_req, 0);
      chk("sw_badva", badvaddr, 32'h0000_1002);
      memwrite = 2'b10; wdata = 32'h1234_ABCD;
      #2;
      chk("sh_ades", exp_ades, 0);
      chk("sh_wstrb", data_wstrb, 4'b1100);
      chk("sh_wdata", data_wdata, 32'hABCD_ABCD);
      chk("sh_size", data_size, 1);
      mem_valid = 0; memwrite = 2'b00;
      // LB with addr_ok withheld for three cycles
      tick();
      mem_valid = 1; memread = 3'b010; addr = 32'h0000_2007;
      for (int i = 0; i < 3; i++) begin
         #2;
         chk("hold_req", data_req, 1);
         chk("hold_addr", data_addr, 32'h0000_2007);
         chk("hold_size", data_size, 0);
         chk("hold_stall", stall_out, 1);
         tick();
      end
      data_addr_ok = 1;
      #2;
      chk("hold_acc_req", data_req, 1);
      tick();
      data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h1122_3344;
      tick();
      data_data_ok = 0; stall_in = 1;
      #2;
      chk("lb_rdata", rdata_out, 32'h1122_3344);
      // DONE held by stall_in
      for (int i = 0; i < 4; i++) begin
         data_rdata = 32'hFFFF_0000 + i;
         #2;
         chk("done_rdata", rdata_out, 32'h1122_3344);
         chk("done_stall", stall_out, 0);
         chk("done_req", data_req, 0);
         tick();
      end
      stall_in = 0;
      tick();
      mem_valid = 0; memread = 3'b111;
      // flush while waiting, stale data_ok absorbed by DRAIN
      tick();
      mem_valid = 1; memread = 3'b000; addr = 32'h0000_3000; data_addr_ok = 1;
      tick();
      data_addr_ok = 0; flush = 1;
      #2;
      chk("fl_stall", stall_out, 1);
      tick();
      flush = 0; addr = 32'h0000_4000;
      #2;
      chk("drain_req", data_req, 0);
      chk("drain_stall", stall_out, 1);
      tick();
      data_data_ok = 1; data_rdata = 32'hBAD0_BAD0;
      #2;
      chk("drain_ok_req", data_req, 0);
      chk("drain_rdata", rdata_out, 32'h1122_3344);
      tick();
      data_data_ok = 0;
      #2;
      chk("post_rdata", rdata_out, 32'h1122_3344);
      chk("post_req", data_req, 1);
      chk("post_addr", data_addr, 32'h0000_4000);
      data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'hCAFE_F00D;
      tick();
      data_addr_ok = 0; data_data_ok = 0;
      #2;
      chk("post_done_rdata", rdata_out, 32'hCAFE_F00D);
      chk("post_done_stall", stall_out, 0);
      tick();
      mem_valid = 0; memread = 3'b111;
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
